// File: rtl/vga_text_writer.sv
// vga_text_writer: byte-stream text writer for the 12x3 VGA text display.
// Edits a shadow buffer and commits it to the display buffer on vsync fall.
module vga_text_writer #(
    parameter int COLS = 12,
    parameter int ROWS = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ch_valid,
    input  logic [7:0]               ch_data,
    output logic                     ch_ready,
    input  logic                     vsync,
    output logic [8*COLS*ROWS-1:0]   disp_buf,
    output logic [1:0]               cursor_row,
    output logic [3:0]               cursor_col,
    output logic                     commit
);

    localparam int         N        = COLS * ROWS;
    localparam int         W        = 8 * N;
    localparam logic [3:0] LAST_COL = 4'(COLS - 1);
    localparam logic [1:0] LAST_ROW = 2'(ROWS - 1);
    localparam logic [8:0] ROW_STEP = 9'(8 * COLS);

    typedef enum logic [1:0] {
        IDLE,
        SCROLL,
        CLEAR
    } state_e;

    state_e         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [1:0]     row_q, row_d;
    logic [3:0]     col_q, col_d;
    logic [W-1:0]   shadow_q, shadow_d;
    logic [W-1:0]   disp_q;
    logic           commit_q;
    logic           pend_q, pend_d;
    logic           vsync_q;

    logic           accept;
    logic           is_print;
    logic           is_nl;
    logic           is_bs;
    logic           is_ff;
    logic           at_last_col;
    logic           at_last_row;
    logic [5:0]     cur_idx;
    logic [8:0]     cur_off;
    logic [8:0]     bs_off;
    logic [8:0]     c_off0;
    logic [8:0]     c_off1;
    logic [8:0]     c_off2;
    logic           vs_fall;
    logic           do_commit;

    assign accept      = ch_valid && ch_ready;
    assign is_print    = (ch_data >= 8'h20) && (ch_data <= 8'h7E);
    assign is_nl       = (ch_data == 8'h0A);
    assign is_bs       = (ch_data == 8'h08);
    assign is_ff       = (ch_data == 8'h0C);
    assign at_last_col = (col_q == LAST_COL);
    assign at_last_row = (row_q == LAST_ROW);

    // Backspace target is always the cell just before the cursor in
    // row-major order, which also covers the wrap to the previous row.
    assign cur_idx = 6'(row_q) * 6'(COLS) + 6'(col_q);
    assign cur_off = {cur_idx, 3'b000};
    assign bs_off  = cur_off - 9'd8;

    assign c_off0 = {2'b00, cnt_q, 3'b000};
    assign c_off1 = c_off0 + ROW_STEP;
    assign c_off2 = c_off1 + ROW_STEP;

    assign vs_fall   = vsync_q && !vsync;
    assign do_commit = (state_q == IDLE) && (vs_fall || pend_q);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: scroll on overflow past the last row, clear on form feed.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_ff) begin
                        state_d = CLEAR;
                    end else if (is_print && at_last_col && at_last_row) begin
                        state_d = SCROLL;
                    end else if (is_nl && at_last_row) begin
                        state_d = SCROLL;
                    end
                end
            end
            SCROLL, CLEAR: begin
                if (cnt_q == LAST_COL) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs driven from state and registered datapath.
    always_comb begin
        ch_ready   = (state_q == IDLE);
        disp_buf   = disp_q;
        cursor_row = row_q;
        cursor_col = col_q;
        commit     = commit_q;
    end

    // Shadow edits, cursor movement and the column sweep of scroll/clear.
    always_comb begin
        shadow_d = shadow_q;
        row_d    = row_q;
        col_d    = col_q;
        cnt_d    = 4'd0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    unique case (1'b1)
                        is_print: begin
                            shadow_d[cur_off +: 8] = ch_data;
                            if (!at_last_col) begin
                                col_d = col_q + 4'd1;
                            end else begin
                                col_d = 4'd0;
                                if (!at_last_row) begin
                                    row_d = row_q + 2'd1;
                                end
                            end
                        end
                        is_nl: begin
                            col_d = 4'd0;
                            if (!at_last_row) begin
                                row_d = row_q + 2'd1;
                            end
                        end
                        is_bs: begin
                            if (col_q != 4'd0) begin
                                col_d = col_q - 4'd1;
                                shadow_d[bs_off +: 8] = 8'h00;
                            end else if (row_q != 2'd0) begin
                                row_d = row_q - 2'd1;
                                col_d = LAST_COL;
                                shadow_d[bs_off +: 8] = 8'h00;
                            end
                        end
                        is_ff: begin
                            row_d = 2'd0;
                            col_d = 4'd0;
                        end
                        default: begin
                        end
                    endcase
                end
            end
            SCROLL: begin
                shadow_d[c_off0 +: 8] = shadow_q[c_off1 +: 8];
                shadow_d[c_off1 +: 8] = shadow_q[c_off2 +: 8];
                shadow_d[c_off2 +: 8] = 8'h00;
                cnt_d = (cnt_q == LAST_COL) ? 4'd0 : cnt_q + 4'd1;
            end
            CLEAR: begin
                shadow_d[c_off0 +: 8] = 8'h00;
                shadow_d[c_off1 +: 8] = 8'h00;
                shadow_d[c_off2 +: 8] = 8'h00;
                cnt_d = (cnt_q == LAST_COL) ? 4'd0 : cnt_q + 4'd1;
            end
            default: begin
            end
        endcase
    end

    // A fall seen while busy is remembered until the writer is idle again.
    always_comb begin
        if (do_commit) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q || vs_fall;
        end
    end

    // Shadow buffer, cursor and sweep counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            row_q    <= 2'd0;
            col_q    <= 4'd0;
            cnt_q    <= 4'd0;
        end else begin
            shadow_q <= shadow_d;
            row_q    <= row_d;
            col_q    <= col_d;
            cnt_q    <= cnt_d;
        end
    end

    // Frame commit: copy the pre-edge shadow so same-cycle writes wait a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q   <= '0;
            commit_q <= 1'b0;
            pend_q   <= 1'b0;
            vsync_q  <= 1'b1;
        end else begin
            vsync_q  <= vsync;
            pend_q   <= pend_d;
            commit_q <= do_commit;
            if (do_commit) begin
                disp_q <= shadow_q;
            end
        end
    end

endmodule

// File: tb/tb_vga_text_writer.sv
// tb_vga_text_writer: directed bench with a frame scoreboard.
// Expected frames are queued at each vsync fall and popped on commit.
module tb_vga_text_writer;

    logic         clk;
    logic         rst_n;
    logic         ch_valid;
    logic [7:0]   ch_data;
    logic         ch_ready;
    logic         vsync;
    logic [287:0] disp_buf;
    logic [1:0]   cursor_row;
    logic [3:0]   cursor_col;
    logic         commit;

    int checks = 0;
    int errors = 0;
    int commits = 0;

    logic [7:0]   m_sh [36];
    int           mr;
    int           mc;
    logic [287:0] exp_q [$];

    vga_text_writer #(.COLS(12), .ROWS(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ch_valid   (ch_valid),
        .ch_data    (ch_data),
        .ch_ready   (ch_ready),
        .vsync      (vsync),
        .disp_buf   (disp_buf),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
        .commit     (commit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [287:0] got,
                       input logic [287:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [287:0] pack();
        logic [287:0] v;
        v = '0;
        for (int i = 0; i < 36; i++) v[8*i +: 8] = m_sh[i];
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 36; i++) m_sh[i] = 8'h00;
        mr = 0;
        mc = 0;
    endtask

    task automatic model_scroll();
        for (int c = 0; c < 12; c++) begin
            m_sh[c]      = m_sh[c + 12];
            m_sh[c + 12] = m_sh[c + 24];
            m_sh[c + 24] = 8'h00;
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            m_sh[mr*12 + mc] = b;
            if (mc < 11) mc++;
            else if (mr < 2) begin mr++; mc = 0; end
            else begin mc = 0; model_scroll(); end
        end else if (b == 8'h0A) begin
            mc = 0;
            if (mr < 2) mr++;
            else model_scroll();
        end else if (b == 8'h08) begin
            if (mc > 0) begin
                mc--;
                m_sh[mr*12 + mc] = 8'h00;
            end else if (mr > 0) begin
                mr--;
                mc = 11;
                m_sh[mr*12 + mc] = 8'h00;
            end
        end else if (b == 8'h0C) begin
            model_clear();
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ch_valid = 1'b0;
        ch_data  = 8'h00;
        vsync    = 1'b1;
        rst_n    = 1'b0;
        model_clear();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        ch_valid = 1'b1;
        ch_data  = b;
        while (!ch_ready && n < 50) begin
            tick();
            n++;
        end
        chk("ready_wait", ch_ready, 1'b1);
        tick();
        ch_valid = 1'b0;
        model_byte(b);
    endtask

    task automatic pulse_vsync(input bit push);
        if (push) exp_q.push_back(pack());
        vsync = 1'b0;
        tick();
        vsync = 1'b1;
    endtask

    task automatic wait_commit(input string tag);
        int n;
        n = 0;
        while (!commit && n < 40) begin
            tick();
            n++;
        end
        chk(tag, commit, 1'b1);
    endtask

    task automatic busy_len(output int n);
        n = 0;
        while (!ch_ready && n < 40) begin
            tick();
            n++;
        end
    endtask

    // Scoreboard: every commit pops and compares one expected frame.
    always @(negedge clk) begin
        if (commit) begin
            commits++;
            chk("commit_expected", (exp_q.size() != 0), 1'b1);
            if (exp_q.size() != 0) chk("commit_frame", disp_buf, exp_q.pop_front());
        end
    end

    initial begin
        int n;
        int base;
        logic [287:0] v;

        do_reset();
        chk("rst_disp", disp_buf, '0);
        chk("rst_row", cursor_row, 2'd0);
        chk("rst_col", cursor_col, 4'd0);
        chk("rst_ready", ch_ready, 1'b1);
        chk("rst_commit", commit, 1'b0);

        // HELLO back-to-back
        send(8'h48); chk("hello_rdy", ch_ready, 1'b1);
        send(8'h45); chk("hello_rdy", ch_ready, 1'b1);
        send(8'h4C); chk("hello_rdy", ch_ready, 1'b1);
        send(8'h4C); chk("hello_rdy", ch_ready, 1'b1);
        send(8'h4F); chk("hello_rdy", ch_ready, 1'b1);
        chk("hello_row", cursor_row, 2'd0);
        chk("hello_col", cursor_col, 4'd5);
        chk("hello_disp_pre", disp_buf, '0);
        pulse_vsync(1'b1);
        chk("hello_commit", commit, 1'b1);
        v = '0;
        v[39:0] = 40'h4F4C4C4548;
        chk("hello_disp", disp_buf, v);
        tick();
        chk("hello_commit_off", commit, 1'b0);

        // byte accepted on a commit edge lands in the next frame
        exp_q.push_back(pack());
        ch_valid = 1'b1;
        ch_data  = 8'h51;
        vsync    = 1'b0;
        tick();
        ch_valid = 1'b0;
        vsync    = 1'b1;
        model_byte(8'h51);
        chk("same_cycle_commit", commit, 1'b1);
        chk("same_cycle_disp", disp_buf, v);
        tick();
        pulse_vsync(1'b1);
        chk("next_frame_cell5", disp_buf[47:40], 8'h51);

        // 36 bytes with wrap and scroll
        do_reset();
        for (int k = 0; k < 36; k++) send(8'(8'h41 + k));
        chk("fill_row", cursor_row, 2'd2);
        chk("fill_col", cursor_col, 4'd0);
        busy_len(n);
        chk("fill_busy", 32'(n), 32'd12);
        pulse_vsync(1'b1);
        chk("fill_commit", commit, 1'b1);
        chk("fill_c0", disp_buf[7:0], 8'h4D);
        chk("fill_c11", disp_buf[95:88], 8'h58);
        chk("fill_c12", disp_buf[103:96], 8'h59);
        chk("fill_c23", disp_buf[191:184], 8'h64);
        chk("fill_row2", disp_buf[287:192], '0);

        // backspace and clear
        do_reset();
        send(8'h08);
        chk("bs00_row", cursor_row, 2'd0);
        chk("bs00_col", cursor_col, 4'd0);
        chk("bs00_rdy", ch_ready, 1'b1);
        send(8'h41);
        send(8'h0A);
        send(8'h08);
        chk("bs_row", cursor_row, 2'd0);
        chk("bs_col", cursor_col, 4'd11);
        pulse_vsync(1'b1);
        chk("bs_c0", disp_buf[7:0], 8'h41);
        chk("bs_c11", disp_buf[95:88], 8'h00);
        send(8'h48);
        send(8'h49);
        chk("hi_row", cursor_row, 2'd1);
        send(8'h0C);
        chk("ff_row", cursor_row, 2'd0);
        chk("ff_col", cursor_col, 4'd0);
        busy_len(n);
        chk("ff_busy", 32'(n), 32'd12);
        pulse_vsync(1'b1);
        chk("ff_commit", commit, 1'b1);
        chk("ff_disp", disp_buf, '0);

        // vsync falls twice during a scroll
        do_reset();
        base = commits;
        for (int k = 0; k < 36; k++) send(8'(8'h30 + k));
        tick();
        tick();
        exp_q.push_back(pack());
        vsync = 1'b0;
        chk("scr_no_commit", commit, 1'b0);
        tick();
        vsync = 1'b1;
        tick();
        tick();
        pulse_vsync(1'b0);
        n = 0;
        while (!ch_ready && n < 40) begin
            chk("scr_no_commit", commit, 1'b0);
            tick();
            n++;
        end
        chk("scr_idle", ch_ready, 1'b1);
        chk("scr_commit_pre", commit, 1'b0);
        tick();
        chk("scr_commit", commit, 1'b1);
        chk("scr_disp", disp_buf, pack());
        tick();
        chk("scr_commit_off", commit, 1'b0);
        repeat (5) tick();
        chk("scr_one_commit", 32'(commits - base), 32'd1);

        // reset in the middle of a scroll
        do_reset();
        send(8'h48);
        send(8'h49);
        pulse_vsync(1'b1);
        wait_commit("mid_pre_commit");
        for (int k = 0; k < 34; k++) send(8'h2E);
        repeat (5) tick();
        chk("mid_busy", ch_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_disp", disp_buf, '0);
        chk("mid_row", cursor_row, 2'd0);
        chk("mid_col", cursor_col, 4'd0);
        chk("mid_ready", ch_ready, 1'b1);
        model_clear();
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(8'h5A);
        pulse_vsync(1'b1);
        wait_commit("mid_commit");
        chk("mid_z", disp_buf[7:0], 8'h5A);

        tick();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
